block_accumulator: RTL and testbench
====================================

// Module: block_accumulator
// PURPOSE
//  Sequencer that accumulates BLOCK_LEN signed 16-bit samples per output word.
//  Drives the operand inputs of an external 16-bit ripple carry adder and registers its sum.
//  Sits between the sample stream (upstream valid/ready) and the decimated result stream.
//  Uses one adder pass per accepted sample.
// PARAMETERS
//  BLOCK_LEN  8  samples summed per output word; legal range 1..65535
//  CNT_W      16  counter width; must satisfy 2**CNT_W >= BLOCK_LEN
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  rst_n      in   1   reset, synchronous, active-low
//  flush      in   1   abandon current block; clear accumulator, counter and flag
//  in_valid   in   1   upstream sample valid
//  in_ready   out  1   block can accept a sample
//  in_data    in   16  signed two's-complement sample
//  adder_a    out  16  adder operand A = acc register
//  adder_b    out  16  adder operand B = in_data
//  adder_cin  out  1   adder carry-in, tied 0
//  adder_sum  in   16  adder result (combinational, same cycle)
//  adder_cout in   1   adder carry-out (unused for signed; kept for lint)
//  out_valid  out  1   result word valid
//  out_ready  in   1   downstream accepts result
//  out_data   out  16  block sum
//  ovf_flag   out  1   sticky: signed overflow occurred in the current block
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=ACCUM, acc=0, cnt=0, out_valid=0, out_data=0, ovf_flag=0.
//  in_ready = (state==ACCUM); combinational, no dependency on in_valid.
//  Accept = in_valid & in_ready. adder_a/adder_b/adder_cin are purely combinational.
//  Overflow: ovf = (acc[15]==in_data[15]) & (adder_sum[15]!=acc[15]).
//  next = ovf ? saturated/wrapped value (see CONFIGURATION) : adder_sum.
//  ACCUM, accept, cnt<BLOCK_LEN-1: acc<=next, cnt<=cnt+1, ovf_flag<=ovf_flag|ovf.
//  ACCUM, accept, cnt==BLOCK_LEN-1: out_data<=next, out_valid<=1, acc<=0, cnt<=0,
//   ovf_flag<=ovf_flag|ovf, state<=HOLD. Latency: last sample to out_valid = 1 cycle.
//  HOLD: out_data and out_valid stable until out_ready=1. On out_ready: out_valid<=0,
//   ovf_flag<=0, state<=ACCUM. in_ready=0 for the whole HOLD phase, including the handshake cycle.
//  BLOCK_LEN=1: every accepted sample produces one output (acc=0, so out_data=in_data).
//  flush (any state) takes priority over accept and out handshake: acc<=0, cnt<=0,
//   ovf_flag<=0, out_valid<=0, state<=ACCUM. A pending HOLD result is discarded.
//  Reset mid-block: partial sum discarded. No output for that block.
//  adder_cout is ignored; signed overflow is derived only from sign bits.
// CONFIGURATION
//  BLOCK_ACC_SAT_EN defined: on ovf, next = acc[15] ? 16'h8000 : 16'h7FFF (clamp).
//   After clamping, accumulation continues from the clamped value.
//  BLOCK_ACC_SAT_EN undefined: next = adder_sum always (modulo 2^16 wrap).
//  ovf_flag is reported identically in both builds.
// TESTING
//  1 BLOCK_LEN=4, samples 1,2,3,4, out_ready=1 -> out_data=10 one cycle after 4th; ovf_flag=0
//  2 Samples 0x7000,0x7000,1,1, SAT_EN -> out_data=0x7FFF, ovf_flag=1;
//    same stimulus without SAT_EN -> out_data=0xE002, ovf_flag=1
//  3 Samples -5,-5,-5,-5 -> out_data=0xFFEC (-20); hold out_ready=0 for 10 cycles:
//    out_data stable, in_ready=0; then out_ready=1 -> in_ready=1 next cycle
//  4 Two samples accepted, then flush=1 with in_valid=1 -> sample ignored; next 4 samples 1 each -> out_data=4
//  5 rst_n=0 for one cycle after 3 samples -> all outputs 0; next full block sums correctly
//  6 BLOCK_LEN=1, samples 7,-7 with out_ready=1 -> out_data 7 then 0xFFF9; in_ready low 1 cycle each

Source files
------------

// File: rtl/block_accumulator.sv
// Block accumulator: sums BLOCK_LEN signed 16-bit samples per result word, driving an external adder.
// Optional clamp-on-overflow arithmetic is selected with `define BLOCK_ACC_SAT_EN (default: modulo wrap).
module block_accumulator #(
  parameter int unsigned BLOCK_LEN = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic [15:0] adder_a,
  output logic [15:0] adder_b,
  output logic        adder_cin,
  input  logic [15:0] adder_sum,
  input  logic        adder_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        ovf_flag
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

  state_t           state, state_nxt;
  logic [15:0]      acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [15:0]      out_data_nxt;
  logic             out_valid_nxt;
  logic             ovf_flag_nxt;
  logic             accept;
  logic             ovf;
  logic [15:0]      next;
  logic             unused_cout;

  // The adder's carry-out carries no meaning for signed data.
  assign unused_cout = adder_cout;

  assign in_ready  = (state == ACCUM);
  assign accept    = in_valid & in_ready;
  assign adder_a   = acc;
  assign adder_b   = in_data;
  assign adder_cin = 1'b0;

  // Signed overflow: both operands share a sign the result does not.
  assign ovf = (acc[15] == in_data[15]) & (adder_sum[15] != acc[15]);

`ifdef BLOCK_ACC_SAT_EN
  logic [15:0] sat_val;
  assign sat_val = acc[15] ? 16'h8000 : 16'h7FFF;
  assign next    = ovf ? sat_val : adder_sum;
`else
  assign next = adder_sum;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    state_nxt     = state;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    ovf_flag_nxt  = ovf_flag;

    if (flush) begin
      // Abandon everything, including a result still waiting in HOLD.
      state_nxt     = ACCUM;
      acc_nxt       = '0;
      cnt_nxt       = '0;
      out_valid_nxt = 1'b0;
      ovf_flag_nxt  = 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            ovf_flag_nxt = ovf_flag | ovf;
            if (cnt == LAST_IDX) begin
              out_data_nxt  = next;
              out_valid_nxt = 1'b1;
              acc_nxt       = '0;
              cnt_nxt       = '0;
              state_nxt     = HOLD;
            end else begin
              acc_nxt = next;
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_nxt = 1'b0;
            ovf_flag_nxt  = 1'b0;
            state_nxt     = ACCUM;
          end
        end
        default: state_nxt = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
      ovf_flag  <= ovf_flag_nxt;
    end
  end

endmodule

// File: tb/tb_block_accumulator.sv
// Bench for block_accumulator: two instances (BLOCK_LEN 4 and 1) share stimulus and are compared
// every cycle against an integer-arithmetic block model, plus hand-computed directed checks.
module tb_block_accumulator;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [15:0] in_data;

  logic        in_ready4, adder_cin4, adder_cout4, out_valid4, ovf4;
  logic [15:0] adder_a4, adder_b4, adder_sum4, out_data4;
  logic        in_ready1, adder_cin1, adder_cout1, out_valid1, ovf1;
  logic [15:0] adder_a1, adder_b1, adder_sum1, out_data1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // External ripple-carry adders modelled behaviourally.
  assign {adder_cout4, adder_sum4} = {1'b0, adder_a4} + {1'b0, adder_b4} + {16'b0, adder_cin4};
  assign {adder_cout1, adder_sum1} = {1'b0, adder_a1} + {1'b0, adder_b1} + {16'b0, adder_cin1};

  block_accumulator #(.BLOCK_LEN(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .adder_a(adder_a4), .adder_b(adder_b4), .adder_cin(adder_cin4),
    .adder_sum(adder_sum4), .adder_cout(adder_cout4), .out_valid(out_valid4),
    .out_ready(out_ready), .out_data(out_data4), .ovf_flag(ovf4)
  );

  block_accumulator #(.BLOCK_LEN(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .adder_a(adder_a1), .adder_b(adder_b1), .adder_cin(adder_cin1),
    .adder_sum(adder_sum1), .adder_cout(adder_cout1), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .ovf_flag(ovf1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: lane 0 = BLOCK_LEN 4, lane 1 = BLOCK_LEN 1. Running block sum kept as a plain integer.
  int lens [2] = '{4, 1};
  int mval [2];
  int mcnt [2];
  int mout [2];
  bit mhold[2];
  bit movf [2];
  bit model_ok = 1'b0;

  function automatic int add_sample(input int l, input int x);
    int     s;
    shortint t;
    s = mval[l] + x;
    if (s > 32767 || s < -32768) begin
      movf[l] = 1'b1;
`ifdef BLOCK_ACC_SAT_EN
      s = (s > 0) ? 32767 : -32768;
`else
      t = shortint'(s);
      s = t;
`endif
    end
    return s;
  endfunction

  function automatic void step(input int l);
    shortint x;
    x = shortint'(in_data);
    if (!rst_n) begin
      mval[l] = 0; mcnt[l] = 0; mout[l] = 0; mhold[l] = 1'b0; movf[l] = 1'b0;
    end else if (flush) begin
      mval[l] = 0; mcnt[l] = 0; mhold[l] = 1'b0; movf[l] = 1'b0;
    end else if (mhold[l]) begin
      if (out_ready) begin
        mhold[l] = 1'b0;
        movf[l]  = 1'b0;
      end
    end else if (in_valid) begin
      mval[l] = add_sample(l, int'(x));
      mcnt[l]++;
      if (mcnt[l] == lens[l]) begin
        mout[l]  = mval[l];
        mval[l]  = 0;
        mcnt[l]  = 0;
        mhold[l] = 1'b1;
      end
    end
  endfunction

  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) step(l);
    if (!rst_n) model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("lane4", {in_ready4, out_valid4, ovf4, adder_cin4, out_data4, adder_a4, adder_b4},
            {!mhold[0], mhold[0], movf[0], 1'b0, 16'(mout[0]), 16'(mval[0]), in_data});
      check("lane1", {in_ready1, out_valid1, ovf1, adder_cin1, out_data1, adder_a1, adder_b1},
            {!mhold[1], mhold[1], movf[1], 1'b0, 16'(mout[1]), 16'(mval[1]), in_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_state4", {in_ready4, out_valid4, ovf4, out_data4, adder_a4}, {3'b100, 32'h0});
    check("rst_state1", {in_ready1, out_valid1, ovf1, out_data1, adder_a1}, {3'b100, 32'h0});

    // 1: 1+2+3+4
    out_ready = 1'b1;
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    in_valid = 1'b0;
    check("sum10", {out_valid4, ovf4, out_data4}, {2'b10, 16'd10});
    tick();
    check("sum10_done", {out_valid4, in_ready4}, 2'b01);

    // 2: overflow
    out_ready = 1'b0;
    send(16'h7000); send(16'h7000); send(16'h0001); send(16'h0001);
    in_valid = 1'b0;
`ifdef BLOCK_ACC_SAT_EN
    check("ovf_sum", {out_valid4, ovf4, out_data4}, {2'b11, 16'h7FFF});
`else
    check("ovf_sum", {out_valid4, ovf4, out_data4}, {2'b11, 16'hE002});
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ovf_cleared", {out_valid4, ovf4, in_ready4}, 3'b001);

    // 3: negative sum, long back-pressure
    send(16'hFFFB); send(16'hFFFB); send(16'hFFFB); send(16'hFFFB);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      check("hold", {out_valid4, in_ready4, ovf4, out_data4}, {3'b100, 16'hFFEC});
      tick();
    end
    out_ready = 1'b1;
    check("hold_handshake", {out_valid4, in_ready4}, 2'b10);
    tick();
    in_valid = 1'b0;
    check("hold_release", {out_valid4, in_ready4, adder_a4}, {2'b01, 16'h0});

    // 4: flush mid-block ignores the concurrent sample
    send(16'd9); send(16'd9);
    flush = 1'b1;
    send(16'd100);
    flush = 1'b0;
    check("flush_clear", {adder_a4, in_ready4}, {16'h0, 1'b1});
    send(16'd1); send(16'd1); send(16'd1); send(16'd1);
    in_valid = 1'b0;
    check("after_flush", {out_valid4, out_data4}, {1'b1, 16'd4});
    tick();

    // 5: reset mid-block
    send(16'd5); send(16'd5); send(16'd5);
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset", {in_ready4, out_valid4, ovf4, out_data4, adder_a4}, {3'b100, 32'h0});
    send(16'd2); send(16'd3); send(16'd4); send(16'd5);
    in_valid = 1'b0;
    check("after_reset", {out_valid4, out_data4}, {1'b1, 16'd14});
    tick();

    // 6: BLOCK_LEN=1 instance
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    send(16'd7);
    check("len1_a", {out_valid1, in_ready1, out_data1}, {2'b10, 16'd7});
    send(16'hFFF9);
    check("len1_gap", {out_valid1, in_ready1}, 2'b01);
    tick();
    check("len1_b", {out_valid1, in_ready1, out_data1}, {2'b10, 16'hFFF9});
    in_valid = 1'b0;
    tick();
    check("len1_done", {out_valid1, in_ready1}, 2'b01);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       in_data = 16'($urandom_range(0, 31)) - 16'd16;
        1:       in_data = 16'h6000 + 16'($urandom_range(0, 16'h1FFF));
        2:       in_data = 16'h8000 + 16'($urandom_range(0, 16'h1FFF));
        default: in_data = 16'($urandom);
      endcase
      tick();
    end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
